irq_nmi_sched: RTL and testbench
================================

Name: irq_nmi_sched

Overview:
Parametrised, synthesizable interrupt-stimulus scheduler for CPU bring-up benches and on-FPGA self-test. It drives the CPU's active-low irq and nmi inputs from NUM_CH independently programmed channels. Each channel is timed against a free-running phase-1 cycle counter and can be one-shot or periodic. It replaces hand-written cycle-window stimulus and sits beside the CPU, clocked on clk_ph1.

Parameters:
NUM_CH, 4, number of scheduling channels (1..16)
CNT_W, 16, width of cycle counter and all timing registers
CH_W, 2, channel-select width; must be >= max(1, clog2(NUM_CH))

Ports:
clk_ph1  in  1  sole clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  counter and channel timing advance only while high
cfg_we  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  target channel; writes to index >= NUM_CH are ignored
cfg_addr  in  2  0=START, 1=LEN, 2=PERIOD, 3=CTRL
cfg_data  in  CNT_W  write data; CTRL uses bit0=en, bit1=periodic, bit2=kind (0 IRQ, 1 NMI)
irq_n  out  1  active-low IRQ: low while any active kind=0 channel asserts
nmi_n  out  1  active-low NMI: low while any active kind=1 channel asserts
ch_active  out  NUM_CH  per-channel ASSERT-state flags
cycle_cnt  out  CNT_W  current counter value

Behaviour:
- Reset: cycle_cnt=0, all START/LEN/PERIOD/CTRL=0, all channels IDLE, irq_n=1, nmi_n=1, ch_active=0. Reset overrides cfg_we and enable in the same cycle.
- cycle_cnt increments by 1 per clock while enable=1 and wraps modulo 2^CNT_W. While enable=0, counter and per-channel LEN countdowns freeze and outputs hold.
- Each channel has a match register MATCH and a countdown REM. States: IDLE, WAIT, ASSERT, DONE.
- CTRL write with en=1: MATCH<=START, state<=WAIT. The write takes effect even if the channel is mid-ASSERT, which re-arms the channel.
- CTRL write with en=0: state<=IDLE. Line released next cycle.
- START/LEN/PERIOD writes update the register only. They are used at the next arm, match, or period reload.
- WAIT -> ASSERT: on an edge with enable=1 and cycle_cnt==MATCH. REM<=LEN-1. ch_active and the line go low (active) from the following cycle.
- LEN=0: a match causes no assertion. Periodic channels reschedule as below; one-shot channels go to DONE.
- ASSERT: REM decrements each enabled cycle. At REM==0 the channel leaves ASSERT, so the line is low for exactly LEN cycles.
  - Periodic: MATCH<=MATCH+P (mod 2^CNT_W) -> WAIT, where P = PERIOD if PERIOD > LEN, else LEN+1. This guarantees at least one high cycle between pulses.
  - One-shot: -> DONE.
- DONE holds until the next CTRL write.
- irq_n = NOT(OR of ch_active where kind=0). nmi_n = NOT(OR of ch_active where kind=1). Both are registered with no combinational path from cfg inputs.
- The kind bit is sampled at arm time. Rewriting CTRL to change kind re-arms the channel.
- Overlapping channels of the same kind OR together. The line stays low until the last one releases.
- Counter wrap: a MATCH below the current count fires after the wrap. No match is missed or duplicated across the wrap boundary.
- Simultaneous cfg write and match on the same channel: the write wins, and the match is discarded that cycle.

Test Plan:
- Reset, then CH0 START=5, LEN=15, CTRL=0x1 (one-shot IRQ), enable=1 -> irq_n low from the cycle after cycle_cnt==5 for exactly 15 cycles; then high, DONE; nmi_n stays 1 throughout.
- CH1 START=10, LEN=3, PERIOD=8, CTRL=0x7 (periodic NMI) -> nmi_n low pulses of 3 cycles starting after cnt 10, 18, 26, 34; irq_n stays 1.
- CH2 LEN=6, PERIOD=4, periodic IRQ -> effective period 7; six cycles low then one cycle high, repeating; no stuck-low.
- CNT_W=8, CH0 armed at cnt=250 with START=3, LEN=2 -> irq_n low after cnt wraps 255->0 and reaches 3; fires exactly once.
- CH0 and CH3 both IRQ, windows [5,20) and [15,30) -> irq_n low continuously across 5..29; ch_active shows both set during the overlap.
- Mid-ASSERT CTRL write en=0 -> irq_n high next cycle. Assert rst mid-pulse -> all outputs at reset values the next cycle. Freeze with enable=0 for 10 cycles -> pulse length is extended by exactly 10 cycles of wall time.

Source files
------------

// File: rtl/irq_nmi_sched_if.sv
// Configuration write bus for irq_nmi_sched.
// A write is one cycle of cfg_we, addressed by channel and register slot.
interface irq_nmi_sched_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
) ();
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;

  modport master (output cfg_we, cfg_ch, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_addr, cfg_data);
endinterface

// File: rtl/irq_nmi_sched.sv
// Interrupt-stimulus scheduler: NUM_CH channels timed against a free-running
// cycle counter drive the CPU's active-low irq_n / nmi_n lines.
//
// state  | meaning
// IDLE   | disabled, line released
// WAIT   | armed, waiting for cycle_cnt == MATCH
// ASSERT | driving its line, REM counts the remaining enabled cycles
// DONE   | one-shot finished, holds until the next CTRL write
module irq_nmi_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic              enable,
  irq_nmi_sched_if.slave    cfg,
  output logic              irq_n,
  output logic              nmi_n,
  output logic [NUM_CH-1:0] ch_active,
  output logic [CNT_W-1:0]  cycle_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, ASSERT, DONE} ch_state_t;

  localparam logic [1:0] A_START  = 2'd0;
  localparam logic [1:0] A_LEN    = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [CNT_W-1:0]  start_r  [NUM_CH];
  logic [CNT_W-1:0]  len_r    [NUM_CH];
  logic [CNT_W-1:0]  period_r [NUM_CH];
  logic [CNT_W-1:0]  match_r  [NUM_CH];
  logic [CNT_W-1:0]  rem_r    [NUM_CH];
  logic [CNT_W-1:0]  per_eff  [NUM_CH];
  logic [2:0]        ctrl_r   [NUM_CH];
  ch_state_t         state_r  [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] ctrl_wr;
  logic [NUM_CH-1:0] kind_v;
  logic [NUM_CH-1:0] act_d;

  // act_d is next-cycle ch_active, so the lines can be registered in step with it
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
      ctrl_wr[i] = wr_hit[i] && (cfg.cfg_addr == A_CTRL);
      kind_v[i]  = ctrl_r[i][2];
      per_eff[i] = (period_r[i] > len_r[i]) ? period_r[i] : len_r[i] + CNT_W'(1);
      act_d[i]   = ch_active[i];
      if (ctrl_wr[i]) begin
        act_d[i] = 1'b0;
      end else if (enable) begin
        if (state_r[i] == WAIT && cycle_cnt == match_r[i] && len_r[i] != '0)
          act_d[i] = 1'b1;
        else if (state_r[i] == ASSERT && rem_r[i] == '0)
          act_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      cycle_cnt <= '0;
      irq_n     <= 1'b1;
      nmi_n     <= 1'b1;
      ch_active <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        start_r[i]  <= '0;
        len_r[i]    <= '0;
        period_r[i] <= '0;
        ctrl_r[i]   <= '0;
        match_r[i]  <= '0;
        rem_r[i]    <= '0;
        state_r[i]  <= IDLE;
      end
    end else begin
      if (enable) cycle_cnt <= cycle_cnt + CNT_W'(1);
      ch_active <= act_d;
      irq_n     <= ~|(act_d & ~kind_v);
      nmi_n     <= ~|(act_d & kind_v);
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          case (cfg.cfg_addr)
            A_START:  start_r[i]  <= cfg.cfg_data;
            A_LEN:    len_r[i]    <= cfg.cfg_data;
            A_PERIOD: period_r[i] <= cfg.cfg_data;
            default: begin
              ctrl_r[i] <= cfg.cfg_data[2:0];
              if (cfg.cfg_data[0]) begin
                match_r[i] <= start_r[i];
                state_r[i] <= WAIT;
              end else begin
                state_r[i] <= IDLE;
              end
            end
          endcase
        end
        // a CTRL write owns the channel this cycle; a coincident match is dropped
        if (!ctrl_wr[i] && enable) begin
          case (state_r[i])
            WAIT: begin
              if (cycle_cnt == match_r[i]) begin
                if (len_r[i] != '0) begin
                  state_r[i] <= ASSERT;
                  rem_r[i]   <= len_r[i] - CNT_W'(1);
                end else if (ctrl_r[i][1]) begin
                  match_r[i] <= match_r[i] + per_eff[i];
                end else begin
                  state_r[i] <= DONE;
                end
              end
            end
            ASSERT: begin
              if (rem_r[i] == '0) begin
                if (ctrl_r[i][1]) begin
                  match_r[i] <= match_r[i] + per_eff[i];
                  state_r[i] <= WAIT;
                end else begin
                  state_r[i] <= DONE;
                end
              end else begin
                rem_r[i] <= rem_r[i] - CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_irq_nmi_sched.sv
// Directed bench for irq_nmi_sched: a 4-channel/16-bit instance for the main
// scenarios and a 3-channel/8-bit instance for counter wrap and decode limits.
module tb_irq_nmi_sched;
  logic clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  int checks   = 0;
  int failures = 0;

  logic        rst, enable, irq_n, nmi_n;
  logic [3:0]  ch_active;
  logic [15:0] cycle_cnt;
  irq_nmi_sched_if #(.CH_W(2), .CNT_W(16)) cfg_if ();

  irq_nmi_sched #(.NUM_CH(4), .CNT_W(16), .CH_W(2)) dut (
    .clk_ph1(clk_ph1), .rst(rst), .enable(enable), .cfg(cfg_if.slave),
    .irq_n(irq_n), .nmi_n(nmi_n), .ch_active(ch_active), .cycle_cnt(cycle_cnt)
  );

  logic        rst2, enable2, irq2_n, nmi2_n;
  logic [2:0]  ch_active2;
  logic [7:0]  cycle_cnt2;
  irq_nmi_sched_if #(.CH_W(2), .CNT_W(8)) cfg2_if ();

  irq_nmi_sched #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) dut2 (
    .clk_ph1(clk_ph1), .rst(rst2), .enable(enable2), .cfg(cfg2_if.slave),
    .irq_n(irq2_n), .nmi_n(nmi2_n), .ch_active(ch_active2), .cycle_cnt(cycle_cnt2)
  );

  task automatic step();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] ch, input logic [1:0] addr, input logic [15:0] data);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = ch; cfg_if.cfg_addr = addr; cfg_if.cfg_data = data;
    step();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic cfg_wr2(input logic [1:0] ch, input logic [1:0] addr, input logic [7:0] data);
    cfg2_if.cfg_we = 1'b1; cfg2_if.cfg_ch = ch; cfg2_if.cfg_addr = addr; cfg2_if.cfg_data = data;
    step();
    cfg2_if.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0; cfg_if.cfg_we = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int lows;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (cycle_cnt !== 16'd3) begin failures++; $display("FAIL count_run got=%0d exp=3", cycle_cnt); end
    // reset together with a LEN write and enable: reset must win
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_addr = 2'd1; cfg_if.cfg_data = 16'd5;
    rst = 1'b1;
    step();
    rst = 1'b0; cfg_if.cfg_we = 1'b0;
    checks++; if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL reset_irq got=%b exp=1", irq_n); end
    checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL reset_nmi got=%b exp=1", nmi_n); end
    checks++; if (ch_active !== 4'h0) begin failures++; $display("FAIL reset_act got=%h exp=0", ch_active); end
    enable = 1'b0;
    cfg_wr(2'd0, 2'd0, 16'd3);
    cfg_wr(2'd0, 2'd3, 16'h1);
    enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin step(); if (irq_n !== 1'b1) lows++; end
    checks++; if (lows !== 0) begin failures++; $display("FAIL reset_len_zero low_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_oneshot_irq();
    logic exp;
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'd5);
    cfg_wr(2'd0, 2'd1, 16'd15);
    cfg_wr(2'd0, 2'd3, 16'h1);
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp = (k >= 6 && k <= 20) ? 1'b0 : 1'b1;
      checks++; if (irq_n !== exp) begin failures++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq_n, exp); end
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL oneshot_nmi k=%0d got=%b exp=1", k, nmi_n); end
    end
    checks++; if (cycle_cnt !== 16'd30) begin failures++; $display("FAIL oneshot_cnt got=%0d exp=30", cycle_cnt); end
    checks++; if (ch_active !== 4'h0) begin failures++; $display("FAIL oneshot_done got=%h exp=0", ch_active); end
  endtask

  task automatic test_periodic_nmi();
    logic exp;
    do_reset();
    cfg_wr(2'd1, 2'd0, 16'd10);
    cfg_wr(2'd1, 2'd1, 16'd3);
    cfg_wr(2'd1, 2'd2, 16'd8);
    cfg_wr(2'd1, 2'd3, 16'h7);
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp = (k >= 11 && ((k - 11) % 8) < 3) ? 1'b0 : 1'b1;
      checks++; if (nmi_n !== exp) begin failures++; $display("FAIL periodic_nmi k=%0d got=%b exp=%b", k, nmi_n, exp); end
      checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL periodic_irq k=%0d got=%b exp=1", k, irq_n); end
      checks++; if (ch_active !== (exp ? 4'h0 : 4'h2)) begin failures++; $display("FAIL periodic_act k=%0d got=%h exp=%h", k, ch_active, exp ? 4'h0 : 4'h2); end
    end
  endtask

  task automatic test_eff_period();
    logic exp;
    do_reset();
    cfg_wr(2'd2, 2'd0, 16'd2);
    cfg_wr(2'd2, 2'd1, 16'd6);
    cfg_wr(2'd2, 2'd2, 16'd4);
    cfg_wr(2'd2, 2'd3, 16'h3);
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp = (k >= 3 && ((k - 3) % 7) < 6) ? 1'b0 : 1'b1;
      checks++; if (irq_n !== exp) begin failures++; $display("FAIL eff_period k=%0d got=%b exp=%b", k, irq_n, exp); end
    end
  endtask

  task automatic test_overlap();
    logic [3:0] exp_act;
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'd5);
    cfg_wr(2'd0, 2'd1, 16'd15);
    cfg_wr(2'd3, 2'd0, 16'd15);
    cfg_wr(2'd3, 2'd1, 16'd15);
    cfg_wr(2'd0, 2'd3, 16'h1);
    cfg_wr(2'd3, 2'd3, 16'h1);
    enable = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp_act = {(k >= 16 && k <= 30), 2'b00, (k >= 6 && k <= 20)};
      checks++; if (ch_active !== exp_act) begin failures++; $display("FAIL overlap_act k=%0d got=%h exp=%h", k, ch_active, exp_act); end
      checks++; if (irq_n !== ~|exp_act) begin failures++; $display("FAIL overlap_irq k=%0d got=%b exp=%b", k, irq_n, ~|exp_act); end
    end
  endtask

  task automatic test_rearm_and_disable();
    logic exp;
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'd2);
    cfg_wr(2'd0, 2'd1, 16'd10);
    cfg_wr(2'd0, 2'd3, 16'h1);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL rearm_pre got=%b exp=0", irq_n); end
    cfg_wr(2'd0, 2'd0, 16'd12);
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL start_write_only got=%b exp=0", irq_n); end
    cfg_wr(2'd0, 2'd3, 16'h1);
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL rearm_release got=%b exp=1", irq_n); end
    for (int k = 8; k <= 16; k++) begin
      step();
      exp = (k >= 13) ? 1'b0 : 1'b1;
      checks++; if (irq_n !== exp) begin failures++; $display("FAIL rearm_pulse k=%0d got=%b exp=%b", k, irq_n, exp); end
    end
    cfg_wr(2'd0, 2'd3, 16'h0);
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL disable_irq got=%b exp=1", irq_n); end
    checks++; if (ch_active !== 4'h0) begin failures++; $display("FAIL disable_act got=%h exp=0", ch_active); end
    for (int k = 18; k <= 30; k++) begin
      step();
      checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL disable_hold k=%0d got=%b exp=1", k, irq_n); end
    end
  endtask

  task automatic test_write_vs_match();
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'd4);
    cfg_wr(2'd0, 2'd1, 16'd3);
    cfg_wr(2'd0, 2'd3, 16'h1);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (cycle_cnt !== 16'd4) begin failures++; $display("FAIL wvm_cnt got=%0d exp=4", cycle_cnt); end
    cfg_wr(2'd0, 2'd3, 16'h1);
    for (int k = 5; k <= 15; k++) begin
      checks++; if (ch_active !== 4'h0) begin failures++; $display("FAIL write_beats_match k=%0d got=%h exp=0", k, ch_active); end
      step();
    end
  endtask

  task automatic test_freeze();
    int lows;
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'd2);
    cfg_wr(2'd0, 2'd1, 16'd5);
    cfg_wr(2'd0, 2'd3, 16'h1);
    enable = 1'b1;
    lows = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (irq_n === 1'b0) lows++;
      if (c == 4) enable = 1'b0;
      if (c == 14) begin
        checks++; if (cycle_cnt !== 16'd4) begin failures++; $display("FAIL freeze_cnt got=%0d exp=4", cycle_cnt); end
        checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL freeze_hold got=%b exp=0", irq_n); end
        enable = 1'b1;
      end
    end
    checks++; if (lows !== 15) begin failures++; $display("FAIL freeze_len got=%0d exp=15", lows); end
    checks++; if (cycle_cnt !== 16'd30) begin failures++; $display("FAIL freeze_end_cnt got=%0d exp=30", cycle_cnt); end
  endtask

  task automatic test_reset_mid_pulse();
    int lows;
    do_reset();
    cfg_wr(2'd1, 2'd0, 16'd3);
    cfg_wr(2'd1, 2'd1, 16'd4);
    cfg_wr(2'd1, 2'd2, 16'd8);
    cfg_wr(2'd1, 2'd3, 16'h7);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (nmi_n !== 1'b0) begin failures++; $display("FAIL midrst_pre got=%b exp=0", nmi_n); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL midrst_nmi got=%b exp=1", nmi_n); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL midrst_irq got=%b exp=1", irq_n); end
    checks++; if (ch_active !== 4'h0) begin failures++; $display("FAIL midrst_act got=%h exp=0", ch_active); end
    checks++; if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cycle_cnt); end
    lows = 0;
    for (int i = 0; i < 20; i++) begin step(); if (nmi_n !== 1'b1) lows++; end
    checks++; if (lows !== 0) begin failures++; $display("FAIL midrst_ctrl_cleared low_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_wrap();
    logic exp;
    int   ch1_hits;
    rst2 = 1'b1; enable2 = 1'b0; cfg2_if.cfg_we = 1'b0;
    step();
    rst2 = 1'b0;
    // ch1 loaded but never armed; a CTRL write to absent ch3 must not reach it
    cfg_wr2(2'd1, 2'd0, 8'd20);
    cfg_wr2(2'd1, 2'd1, 8'd2);
    cfg_wr2(2'd3, 2'd3, 8'h1);
    enable2 = 1'b1;
    ch1_hits = 0;
    for (int i = 0; i < 250; i++) begin step(); if (ch_active2[1] !== 1'b0) ch1_hits++; end
    checks++; if (cycle_cnt2 !== 8'd250) begin failures++; $display("FAIL wrap_cnt got=%0d exp=250", cycle_cnt2); end
    cfg_wr2(2'd0, 2'd0, 8'd3);
    cfg_wr2(2'd0, 2'd1, 8'd2);
    cfg_wr2(2'd0, 2'd3, 8'h1);
    for (int j = 1; j <= 300; j++) begin
      step();
      if (ch_active2[1] !== 1'b0) ch1_hits++;
      exp = (j == 7 || j == 8) ? 1'b0 : 1'b1;
      checks++; if (irq2_n !== exp) begin failures++; $display("FAIL wrap_irq j=%0d cnt=%0d got=%b exp=%b", j, cycle_cnt2, irq2_n, exp); end
    end
    checks++; if (ch1_hits !== 0) begin failures++; $display("FAIL wrap_bad_decode hits=%0d exp=0", ch1_hits); end
    checks++; if (nmi2_n !== 1'b1) begin failures++; $display("FAIL wrap_nmi got=%b exp=1", nmi2_n); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    rst2 = 1'b1; enable2 = 1'b0;
    cfg2_if.cfg_we = 1'b0; cfg2_if.cfg_ch = '0; cfg2_if.cfg_addr = '0; cfg2_if.cfg_data = '0;
    test_reset();
    test_oneshot_irq();
    test_periodic_nmi();
    test_eff_period();
    test_overlap();
    test_rearm_and_disable();
    test_write_vs_match();
    test_freeze();
    test_reset_mid_pulse();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
